// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - state encoding and default constants for the button debouncer
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW   = 2'd0,
      CHECK_HIGH = 2'd1,
      IDLE_HIGH  = 2'd2,
      CHECK_LOW  = 2'd3
   } debState_t;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int GLITCH_W            = 8;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchronizer with async reset to a chosen idle level
module sync_chain
   import debounce_pkg::*;
#(
   parameter int   DEPTH = DEF_SYNC_STAGES,
   parameter logic IDLE  = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic dataIn,
   output logic dataOut
);

   logic [DEPTH-1:0] stages;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stages <= {DEPTH{IDLE}};
      end else begin
         stages <= {stages[DEPTH-2:0], dataIn};
      end
   end

   assign dataOut = stages[DEPTH-1];

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizes and debounces a mechanical button, counting aborted checks
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                RawButton,
   output logic                Debounced,
   output logic                Busy,
   output logic [GLITCH_W-1:0] GlitchCount
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (SYNC_STAGES < 2) begin : gBadSyncStages
      $error("button_debouncer: SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : gBadDebounceCycles
      $error("button_debouncer: DEBOUNCE_CYCLES must be at least 1");
   end

   logic       syncOut;
   logic       s;
   debState_t  state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic       abort;

   // Reset the chain to the raw level that reads as "released" after inversion.
   sync_chain #(
      .DEPTH (SYNC_STAGES),
      .IDLE  (ACTIVE_LOW != 0)
   ) uSync (
      .clk     (clk),
      .rst     (rst),
      .dataIn  (RawButton),
      .dataOut (syncOut)
   );

   assign s = (ACTIVE_LOW != 0) ? ~syncOut : syncOut;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE_LOW;
         cnt         <= '0;
         GlitchCount <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         if (abort && (GlitchCount != '1)) begin
            GlitchCount <= GlitchCount + GLITCH_W'(1);
         end
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      abort     = 1'b0;
      case (state)
         IDLE_LOW: begin
            if (s) begin
               stateNext = CHECK_HIGH;
               cntNext   = '0;
            end
         end
         CHECK_HIGH: begin
            if (!s) begin
               stateNext = IDLE_LOW;
               abort     = 1'b1;
            end else if (cnt == CNT_LAST) begin
               stateNext = IDLE_HIGH;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         IDLE_HIGH: begin
            if (!s) begin
               stateNext = CHECK_LOW;
               cntNext   = '0;
            end
         end
         CHECK_LOW: begin
            if (s) begin
               stateNext = IDLE_HIGH;
               abort     = 1'b1;
            end else if (cnt == CNT_LAST) begin
               stateNext = IDLE_LOW;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         default: begin
            stateNext = IDLE_LOW;
            cntNext   = '0;
         end
      endcase
   end

   // Outputs decode registered state only, so RawButton never reaches them combinationally.
   always_comb begin
      Debounced = 1'b0;
      Busy      = 1'b0;
      Debounced = (state == IDLE_HIGH) || (state == CHECK_LOW);
      Busy      = (state == CHECK_HIGH) || (state == CHECK_LOW);
   end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for the button debouncer
module tb_button_debouncer;

   logic       clk = 1'b0;
   logic       rst;
   logic       rawMain, rawLow, rawOne;
   logic       debMain, debLow, debOne;
   logic       busyMain, busyLow, busyOne;
   logic [7:0] gcMain, gcLow, gcOne;

   int vectors     = 0;
   int miscompares = 0;
   logic [9:0] expQ[$];

   always #5 clk = ~clk;

   button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0)) dutMain (
      .clk(clk), .rst(rst), .RawButton(rawMain),
      .Debounced(debMain), .Busy(busyMain), .GlitchCount(gcMain));

   button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) dutLow (
      .clk(clk), .rst(rst), .RawButton(rawLow),
      .Debounced(debLow), .Busy(busyLow), .GlitchCount(gcLow));

   button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(0)) dutOne (
      .clk(clk), .rst(rst), .RawButton(rawOne),
      .Debounced(debOne), .Busy(busyOne), .GlitchCount(gcOne));

   function automatic logic [9:0] observe(input int sel);
      case (sel)
         0:       return {debMain, busyMain, gcMain};
         1:       return {debLow, busyLow, gcLow};
         default: return {debOne, busyOne, gcOne};
      endcase
   endfunction

   task automatic driveRaw(input int sel, input logic raw);
      @(negedge clk);
      case (sel)
         0:       rawMain = raw;
         1:       rawLow  = raw;
         default: rawOne  = raw;
      endcase
      @(posedge clk);
      #1;
   endtask

   // Expected outputs after the edge are queued as the input for that edge is driven.
   task automatic driveEdge(input int sel, input logic raw, input logic expDeb,
                            input logic expBusy, input int expGc);
      expQ.push_back({expDeb, expBusy, 8'(expGc)});
      driveRaw(sel, raw);
   endtask

   task automatic test_reset;
      logic [9:0] got, want;
      rst = 1'b1; rawMain = 1'b0; rawLow = 1'b1; rawOne = 1'b0;
      #1;
      for (int sel = 0; sel < 3; sel++) begin
         got = observe(sel);
         vectors++;
         if (got !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_async dut=%0d: got %b, want 0000000000", sel, got);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         driveEdge(0, 1'b0, 1'b0, 1'b0, 0);
         got = observe(0); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL reset_idle k=%0d: got %b, want %b", k, got, want);
         end
      end
   endtask

   task automatic test_clean_press(input int gcBase);
      logic [9:0] got, want;
      for (int k = 0; k < 10; k++) begin
         driveEdge(0, 1'b1, k >= 6, (k >= 2) && (k <= 5), gcBase);
         got = observe(0); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL clean_press k=%0d: got %b, want %b", k, got, want);
         end
      end
   endtask

   task automatic test_release(input int gcBase);
      logic [9:0] got, want;
      for (int k = 0; k < 10; k++) begin
         driveEdge(0, 1'b0, k < 6, (k >= 2) && (k <= 5), gcBase);
         got = observe(0); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL release k=%0d: got %b, want %b", k, got, want);
         end
      end
   endtask

   task automatic test_low_glitch(input int gcBase);
      logic [9:0] got, want;
      for (int k = 0; k < 10; k++) begin
         driveEdge(0, k >= 3, 1'b1, (k >= 2) && (k <= 4), gcBase + ((k >= 5) ? 1 : 0));
         got = observe(0); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL low_glitch k=%0d: got %b, want %b", k, got, want);
         end
      end
   endtask

   task automatic test_bounce(input int gcBase);
      logic [9:0] got, want;
      logic raw, busy;
      for (int k = 0; k < 12; k++) begin
         raw  = (k < 4) ? (k % 2 == 0) : 1'b1;
         busy = (k == 2) || (k == 4) || ((k >= 6) && (k <= 9));
         driveEdge(0, raw, k >= 10, busy, gcBase + ((k >= 3) ? 1 : 0) + ((k >= 5) ? 1 : 0));
         got = observe(0); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL bounce k=%0d: got %b, want %b", k, got, want);
         end
      end
   endtask

   task automatic test_saturation(input int gcBase);
      logic [9:0] got, want;
      int total;
      total = gcBase;
      for (int batch = 0; batch < 2; batch++) begin
         for (int i = 0; i < ((batch == 0) ? 100 : 200); i++) begin
            driveRaw(0, 1'b1);
            driveRaw(0, 1'b0);
         end
         total = total + ((batch == 0) ? 100 : 200);
         driveRaw(0, 1'b0);
         driveEdge(0, 1'b0, 1'b0, 1'b0, (total > 255) ? 255 : total);
         got = observe(0); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL saturation batch=%0d: got %b, want %b", batch, got, want);
         end
      end
      for (int k = 0; k < 4; k++) begin
         driveEdge(0, k == 0, 1'b0, k == 2, 255);
         got = observe(0); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL saturated_abort k=%0d: got %b, want %b", k, got, want);
         end
      end
   endtask

   task automatic test_async_reset;
      logic [9:0] got, want;
      for (int k = 0; k < 4; k++) begin
         driveEdge(0, 1'b1, 1'b0, k >= 2, 255);
         got = observe(0); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL pre_reset_check k=%0d: got %b, want %b", k, got, want);
         end
      end
      #1 rst = 1'b1;
      #1;
      got = observe(0); vectors++;
      if (got !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_mid_check: got %b, want 0000000000", got);
      end
      #1 rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         driveEdge(0, 1'b1, k >= 6, (k >= 2) && (k <= 5), 0);
         got = observe(0); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL held_after_reset k=%0d: got %b, want %b", k, got, want);
         end
      end
   endtask

   task automatic test_active_low;
      logic [9:0] got, want;
      for (int k = 0; k < 10; k++) begin
         driveEdge(1, 1'b0, k >= 6, (k >= 2) && (k <= 5), 0);
         got = observe(1); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL active_low k=%0d: got %b, want %b", k, got, want);
         end
      end
   endtask

   task automatic test_one_cycle;
      logic [9:0] got, want;
      for (int k = 0; k < 6; k++) begin
         driveEdge(2, 1'b1, k >= 3, k == 2, 0);
         got = observe(2); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL one_cycle_press k=%0d: got %b, want %b", k, got, want);
         end
      end
      for (int k = 0; k < 6; k++) begin
         driveEdge(2, k != 0, 1'b1, k == 2, (k >= 3) ? 1 : 0);
         got = observe(2); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL one_cycle_glitch k=%0d: got %b, want %b", k, got, want);
         end
      end
      for (int k = 0; k < 7; k++) begin
         driveEdge(2, k >= 2, !((k == 3) || (k == 4)), (k == 2) || (k == 4), 1);
         got = observe(2); want = expQ.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL one_cycle_dip k=%0d: got %b, want %b", k, got, want);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got time limit reached, want bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_clean_press(0);
      test_low_glitch(0);
      test_release(1);
      test_bounce(1);
      test_release(3);
      test_saturation(3);
      test_async_reset();
      test_active_low();
      test_one_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on the raw input (legal values 2 to 4).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the consecutive-cycle stability requirement (legal values 1 to 2^20; FPGA builds use 500000).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 0, meaning that when 1 the raw input is inverted after synchronization.
REQ-004 Port: clk  input  1  single system clock; all flops on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: RawButton  input  1  asynchronous, bouncing mechanical button.
REQ-007 Port: Debounced  output  1  clean level; drives a downstream single-pulse stage's level input.
REQ-008 Port: Busy  output  1  high while a stability check is in progress.
REQ-009 Port: GlitchCount  output  8  saturating count of aborted stability checks.

Function
REQ-010 RawButton SHALL pass through a SYNC_STAGES-deep flop chain; s denotes the last stage, inverted when ACTIVE_LOW=1.
REQ-011 The FSM SHALL have 4 states: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW.
REQ-012 IDLE_LOW: s=1 -> CHECK_HIGH with cnt<=0; else stay.
REQ-013 CHECK_HIGH: s=0 -> IDLE_LOW, with GlitchCount incremented; s=1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE_HIGH; otherwise cnt<=cnt+1.
REQ-014 IDLE_HIGH and CHECK_LOW SHALL mirror REQ-012 and REQ-013 with s polarity reversed; an abort from CHECK_LOW returns to IDLE_HIGH and increments GlitchCount.
REQ-015 Debounced SHALL be 1 exactly in IDLE_HIGH and CHECK_LOW, decoded from registered state with no combinational path from RawButton.
REQ-016 Busy SHALL be 1 exactly in CHECK_HIGH and CHECK_LOW.
REQ-017 Latency: taking edge 0 as the first edge capturing a new steady RawButton level, Debounced SHALL change after edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-018 Debounced SHALL change only after s has held the new level for DEBOUNCE_CYCLES+1 consecutive sampling edges.
REQ-019 A level change shorter than that SHALL leave Debounced unchanged.
REQ-020 cnt width SHALL be $clog2(DEBOUNCE_CYCLES+1), and cnt SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-021 With DEBOUNCE_CYCLES=1, the check state SHALL be occupied for exactly one edge.
REQ-022 GlitchCount SHALL saturate at 255 and never wrap.
REQ-023 Simultaneous abort and saturation: the state transition SHALL occur and GlitchCount SHALL hold at 255.
REQ-024 Illegal state encodings SHALL recover to IDLE_LOW on the next edge.

Reset
REQ-025 rst asserted SHALL immediately, without a clock edge, force: sync chain to the idle level (0 after polarity handling), state IDLE_LOW, cnt 0, Debounced 0, Busy 0, GlitchCount 0.
REQ-026 Reset mid-check SHALL abandon the check without incrementing GlitchCount.
REQ-027 After reset deassertion, a button already held SHALL require the full REQ-017 latency before Debounced rises.
REQ-028 Reset SHALL be the only clear of GlitchCount.

Structure
REQ-029 Package debounce_pkg SHALL hold the state enum typedef and the default constants for SYNC_STAGES, DEBOUNCE_CYCLES and the GlitchCount width.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_chain, parameterized by depth, with async reset to a parameterized idle value.
REQ-031 Parameter legality SHALL be checked at elaboration: SYNC_STAGES>=2 and DEBOUNCE_CYCLES>=1.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-032 Clean press: RawButton 0->1 held -> Debounced rises after edge 6, Busy high after edges 2..5, GlitchCount 0.
REQ-033 Bounce: pattern 1,0,1,0 at one edge each, then held 1 -> Debounced rises 6 edges after the final rise, and GlitchCount equals the number of aborted checks (2 expected).
REQ-034 Release: steady 1 then 1->0 held -> Debounced falls after edge 6; a 3-cycle low glitch leaves Debounced at 1 and increments GlitchCount by 1.
REQ-035 Saturation: 300 aborted checks -> GlitchCount reads 255 and stays at 255.
REQ-036 Async reset: rst pulsed between clock edges mid-CHECK_HIGH -> all outputs 0 before the next edge; with RawButton held high, Debounced rises after edge 6 following deassertion.
REQ-037 ACTIVE_LOW=1: RawButton 1->0 held -> Debounced rises after edge 6.
